// File: rtl/prog_sequencer.sv
// prog_sequencer: program-counter sequencer with a writable branch-target LUT.
// FSM IDLE -> RUN -> DONE; start restarts from START_ADDR in any state.
// Next PC in RUN: ret > call > taken branch (relative) > jump (absolute) > +1.
// Optional return-address stack enabled by defining the macro RAS_EN;
// without it call/ret are ignored and stk_err is tied low.
module prog_sequencer #(
  parameter int D          = 12,
  parameter int L          = 3,
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 128,
  parameter int RAS_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stall,
  input  logic         branch,
  input  logic         taken,
  input  logic         jump,
  input  logic         call,
  input  logic         ret,
  input  logic [L-1:0] how_high,
  input  logic         lut_we,
  input  logic [L-1:0] lut_widx,
  input  logic [D-1:0] lut_wdata,
  output logic [D-1:0] prog_ctr,
  output logic         busy,
  output logic         done,
  output logic         stk_err
);

  localparam int NLUT = 1 << L;
  localparam int SPW  = $clog2(RAS_DEPTH + 1);
  localparam logic [D-1:0] START_PC = D'(START_ADDR);
  localparam logic [D-1:0] END_PC   = D'(END_ADDR);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [D-1:0] r_pc;
  logic [D-1:0] w_pc_nxt;
  logic [D-1:0] w_pc_base;
  logic [D-1:0] w_pc_inc;
  logic [D-1:0] w_lut_rd;
  logic         w_run_adv;
  logic [D-1:0] r_lut [NLUT];

  assign prog_ctr  = r_pc;
  assign w_pc_inc  = r_pc + D'(1);
  assign w_lut_rd  = r_lut[how_high];
  // Only a running, non-terminal, non-stalled cycle lets the control inputs steer the PC.
  assign w_run_adv = (r_state == S_RUN) && (r_pc != END_PC) && !stall;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: start wins everywhere; RUN ends when the PC reaches END_ADDR.
  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = S_RUN;
    end else begin
      case (r_state)
        S_RUN:   if (r_pc == END_PC) w_state_nxt = S_DONE;
        S_IDLE:  w_state_nxt = S_IDLE;
        S_DONE:  w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode from the registered state.
  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  // Branch-target LUT: written at the edge, so a same-cycle read sees the old entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NLUT; i++) r_lut[i] <= '0;
    end else if (lut_we) begin
      r_lut[lut_widx] <= lut_wdata;
    end
  end

  // Non-stack PC candidate: taken branch adds a two's-complement offset, wrapping mod 2^D.
  always_comb begin
    w_pc_base = w_pc_inc;
    if (branch && taken) w_pc_base = r_pc + w_lut_rd;
    else if (jump)       w_pc_base = w_lut_rd;
  end

`ifdef RAS_EN
  localparam int AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [D-1:0]   r_stk [RAS_DEPTH];
  logic [SPW-1:0] r_sp;
  logic [SPW-1:0] w_sp_m1;
  logic [D-1:0]   w_stk_top;
  logic           r_stk_err;
  logic           w_push;
  logic           w_pop;
  logic           w_err_set;

  assign w_sp_m1   = r_sp - SPW'(1);
  assign w_stk_top = r_stk[w_sp_m1[AW-1:0]];
  assign stk_err   = r_stk_err;

  // Next-PC selection with the stack: ret over call (so call+ret acts as ret), then base.
  always_comb begin
    w_pc_nxt  = r_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_err_set = 1'b0;
    if (start) begin
      w_pc_nxt = START_PC;
    end else if (w_run_adv) begin
      if (ret) begin
        if (r_sp == '0) begin
          w_err_set = 1'b1;
          w_pc_nxt  = w_pc_inc;
        end else begin
          w_pop    = 1'b1;
          w_pc_nxt = w_stk_top;
        end
      end else if (call) begin
        w_pc_nxt = w_lut_rd;
        if (r_sp == SPW'(RAS_DEPTH)) w_err_set = 1'b1;
        else                         w_push    = 1'b1;
      end else begin
        w_pc_nxt = w_pc_base;
      end
    end
  end

  // Stack pointer and sticky error flag; start empties the stack and clears the flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sp      <= '0;
      r_stk_err <= 1'b0;
    end else if (start) begin
      r_sp      <= '0;
      r_stk_err <= 1'b0;
    end else begin
      if (w_push)     r_sp <= r_sp + SPW'(1);
      else if (w_pop) r_sp <= w_sp_m1;
      if (w_err_set)  r_stk_err <= 1'b1;
    end
  end

  // Stack storage: entries above the pointer are don't-care, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) r_stk[r_sp[AW-1:0]] <= w_pc_inc;
  end
`else
  logic           w_unused_ras;
  logic [SPW-1:0] w_unused_depth;

  assign w_unused_ras   = call ^ ret;
  assign w_unused_depth = SPW'(RAS_DEPTH);
  assign stk_err        = 1'b0;

  // Next-PC selection without a stack: call and ret have no effect.
  always_comb begin
    w_pc_nxt = r_pc;
    if (start)          w_pc_nxt = START_PC;
    else if (w_run_adv) w_pc_nxt = w_pc_base;
  end
`endif

  // Program counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pc <= '0;
    else       r_pc <= w_pc_nxt;
  end

endmodule
